// File: rtl/im_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and
// default memory geometry.
package im_boot_loader_pkg;

   localparam int unsigned DEF_IM_DEPTH  = 1024;
   localparam int unsigned DEF_ADDR_W    = 10;
   localparam logic [31:0] DEF_TEXT_BASE = 32'h0000_3000;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_e;

   // States in which the loader is still consuming the frame
   function automatic logic is_loading(input state_e s);
      return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA) || (s == S_CSUM);
   endfunction

endpackage

// File: rtl/im_boot_loader_if.sv
// Valid/ready byte-stream port feeding the boot loader.
interface im_boot_loader_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );

endinterface

// File: rtl/im_boot_loader_asm.sv
// Word assembler: shifts payload bytes MSB-first into 32-bit words and keeps
// the running XOR checksum of every payload byte.
module im_boot_loader_asm (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clr_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o,
   output logic [7:0]  acc_o
);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [7:0]  acc_q, acc_d;

   always_comb begin
      shift_d = shift_q;
      bcnt_d  = bcnt_q;
      acc_d   = acc_q;
      if (clr_i) begin
         shift_d = '0;
         bcnt_d  = '0;
         acc_d   = '0;
      end else if (byte_en_i) begin
         shift_d = {shift_q[15:0], byte_i};
         bcnt_d  = bcnt_q + 2'd1;
         acc_d   = acc_q ^ byte_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         bcnt_q  <= '0;
         acc_q   <= '0;
      end else begin
         shift_q <= shift_d;
         bcnt_q  <= bcnt_d;
         acc_q   <= acc_d;
      end
   end

   // The fourth byte completes the word combinationally so the write can be
   // registered on the same handshake edge.
   assign word_valid_o = byte_en_i && (bcnt_q == 2'd3);
   assign word_o       = {shift_q, byte_i};
   assign acc_o        = acc_q;

endmodule

// File: rtl/im_boot_loader.sv
// Boot loader: parses a framed program image from a byte stream, writes it into
// instruction memory from word 0 and releases the core once the checksum matches.
module im_boot_loader
   import im_boot_loader_pkg::*;
#(
   parameter int unsigned IM_DEPTH  = DEF_IM_DEPTH,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter logic [31:0] TEXT_BASE = DEF_TEXT_BASE
) (
   input  logic               clk,
   input  logic               rst,
   im_boot_loader_if.slave    bs,
   input  logic               reload,
   output logic               im_we,
   output logic [ADDR_W-1:0]  im_addr,
   output logic [31:0]        im_wdata,
   output logic               cpu_rst,
   output logic               done,
   output logic               err,
   output logic [31:0]        load_base
);

   state_e              state_q, state_d;
   logic [7:0]          cnt_hi_q, cnt_hi_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [15:0]         widx_q, widx_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                cpu_rst_q, cpu_rst_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                rdy_q, rdy_d;

   logic                hs;
   logic                asm_clr;
   logic                word_valid;
   logic [31:0]         word;
   logic [7:0]          acc;
   logic [15:0]         n_rx;

   assign hs   = bs.in_valid & rdy_q;
   assign n_rx = {cnt_hi_q, bs.in_data};

   im_boot_loader_asm u_asm (
      .clk_i        (clk),
      .rst_ni       (rst),
      .clr_i        (asm_clr),
      .byte_en_i    (hs && (state_q == S_DATA)),
      .byte_i       (bs.in_data),
      .word_valid_o (word_valid),
      .word_o       (word),
      .acc_o        (acc)
   );

   always_comb begin
      state_d   = state_q;
      cnt_hi_d  = cnt_hi_q;
      cnt_d     = cnt_q;
      widx_d    = widx_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      asm_clr   = 1'b0;

      case (state_q)
         S_HDR0: begin
            if (hs) begin
               cnt_hi_d = bs.in_data;
               state_d  = S_HDR1;
            end
         end
         S_HDR1: begin
            if (hs) begin
               cnt_d = n_rx;
               if (32'(n_rx) > IM_DEPTH)
                  state_d = S_ERR;
               else if (n_rx == 16'd0)
                  state_d = S_CSUM;
               else
                  state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (word_valid) begin
               we_d    = 1'b1;
               addr_d  = widx_q[ADDR_W-1:0];
               wdata_d = word;
               widx_d  = widx_q + 16'd1;
               if (widx_q == cnt_q - 16'd1)
                  state_d = S_CSUM;
            end
         end
         S_CSUM: begin
            if (hs)
               state_d = (bs.in_data == acc) ? S_DONE : S_ERR;
         end
         S_DONE, S_ERR: begin
            if (reload) begin
               state_d  = S_HDR0;
               cnt_hi_d = '0;
               cnt_d    = '0;
               widx_d   = '0;
               asm_clr  = 1'b1;
            end
         end
         default: state_d = S_HDR0;
      endcase

      // Status outputs are registered from the next state so they line up with
      // the state register and read as idle while reset is held.
      rdy_d     = is_loading(state_d);
      done_d    = (state_d == S_DONE);
      err_d     = (state_d == S_ERR);
      cpu_rst_d = !((state_q == S_DONE) && (state_d == S_DONE));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_HDR0;
         cnt_hi_q  <= '0;
         cnt_q     <= '0;
         widx_q    <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cpu_rst_q <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdy_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_hi_q  <= cnt_hi_d;
         cnt_q     <= cnt_d;
         widx_q    <= widx_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cpu_rst_q <= cpu_rst_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdy_q     <= rdy_d;
      end
   end

   assign bs.in_ready = rdy_q;
   assign im_we       = we_q;
   assign im_addr     = addr_q;
   assign im_wdata    = wdata_q;
   assign cpu_rst     = cpu_rst_q;
   assign done        = done_q;
   assign err         = err_q;
   assign load_base   = TEXT_BASE;

endmodule
